// File: rtl/pipelined_adder_if.sv
// rtl/pipelined_adder_if.sv - operand/result handshake bundle for pipelined_adder
interface pipelined_adder_if #(
    parameter int WIDTH = 16
);
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             ci;
    logic             sub;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] s;
    logic             co;
    logic             ov;
    logic             out_valid;
    logic             out_ready;

    modport master (
        output a, b, ci, sub, in_valid, out_ready,
        input  in_ready, s, co, ov, out_valid
    );

    modport slave (
        input  a, b, ci, sub, in_valid, out_ready,
        output in_ready, s, co, ov, out_valid
    );
endinterface

// File: rtl/pipelined_adder.sv
// rtl/pipelined_adder.sv - WIDTH-bit add/sub, one CW-bit chunk per stage, valid/ready on both sides
module pipelined_adder #(
    parameter int WIDTH  = 16,
    parameter int STAGES = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    pipelined_adder_if.slave bus
);
    localparam int CW   = WIDTH / STAGES;
    localparam int LAST = STAGES - 1;

    logic adv;
    logic ov_q, ov_d;
    logic unused_last_ops;

    genvar k;
    generate
        for (k = 0; k < STAGES; k++) begin : g_stage
            logic             in_v, in_c;
            logic [WIDTH-1:0] in_a, in_b, in_s;
            logic [CW:0]      part;
            logic             v_q, v_d, c_q, c_d;
            logic [WIDTH-1:0] s_q, s_d, a_q, a_d, b_q, b_d;

            // Stage 0 folds subtract into operand inversion plus forced carry-in
            if (k == 0) begin : g_head
                assign in_v = bus.in_valid;
                assign in_c = bus.sub | bus.ci;
                assign in_a = bus.a;
                assign in_b = bus.sub ? ~bus.b : bus.b;
                assign in_s = '0;
            end else begin : g_body
                assign in_v = g_stage[k-1].v_q;
                assign in_c = g_stage[k-1].c_q;
                assign in_a = g_stage[k-1].a_q;
                assign in_b = g_stage[k-1].b_q;
                assign in_s = g_stage[k-1].s_q;
            end

            assign part = {1'b0, in_a[k*CW +: CW]} + {1'b0, in_b[k*CW +: CW]} + {{CW{1'b0}}, in_c};

            // Data only loads behind a valid op so s holds the last result across bubbles
            always_comb begin
                v_d = v_q;
                c_d = c_q;
                s_d = s_q;
                a_d = a_q;
                b_d = b_q;
                if (adv) begin
                    v_d = in_v;
                    if (in_v) begin
                        s_d             = in_s;
                        s_d[k*CW +: CW] = part[CW-1:0];
                        c_d             = part[CW];
                        a_d             = in_a;
                        b_d             = in_b;
                    end
                end
            end

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    v_q <= 1'b0;
                    c_q <= 1'b0;
                    s_q <= '0;
                    a_q <= '0;
                    b_q <= '0;
                end else begin
                    v_q <= v_d;
                    c_q <= c_d;
                    s_q <= s_d;
                    a_q <= a_d;
                    b_q <= b_d;
                end
            end
        end
    endgenerate

    // Carry into the MSB is a^b^s at that bit; overflow is it XOR the carry out
    always_comb begin
        ov_d = ov_q;
        if (adv && g_stage[LAST].in_v) begin
            ov_d = g_stage[LAST].in_a[WIDTH-1] ^ g_stage[LAST].in_b[WIDTH-1]
                 ^ g_stage[LAST].part[CW-1] ^ g_stage[LAST].part[CW];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ov_q <= 1'b0;
        end else begin
            ov_q <= ov_d;
        end
    end

    assign adv           = !g_stage[LAST].v_q || bus.out_ready;
    assign bus.in_ready  = adv;
    assign bus.out_valid = g_stage[LAST].v_q;
    assign bus.s         = g_stage[LAST].s_q;
    assign bus.co        = g_stage[LAST].c_q;
    assign bus.ov        = ov_q;

    // Operand copies in the final stage have no consumer
    assign unused_last_ops = ^{g_stage[LAST].a_q, g_stage[LAST].b_q};
endmodule

// File: tb/tb_pipelined_adder.sv
// tb/tb_pipelined_adder.sv - directed vectors, backpressure, reset and WIDTH=8 sweep for pipelined_adder
module tb_pipelined_adder;
    logic clk;
    logic rst_n;
    int   n_cmp;
    int   n_bad;

    pipelined_adder_if #(.WIDTH(16)) bus ();
    pipelined_adder #(.WIDTH(16), .STAGES(4)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    logic [7:0] sw_a, sw_b;
    logic       sw_ci, sw_sub, sw_in_valid, sw_out_ready, sw_phase1;
    logic [2:0] sw_rdy, sw_vld, sw_co, sw_ov;
    logic [7:0] sw_s [3];
    int         sw_cyc;
    int         sw_exp [3][$];
    int         sw_acc [3][$];

    genvar g;
    generate
        for (g = 0; g < 3; g++) begin : g_sw
            localparam int ST = (g == 0) ? 1 : (g == 1) ? 2 : 8;
            pipelined_adder_if #(.WIDTH(8)) sb ();
            assign sb.a         = sw_a;
            assign sb.b         = sw_b;
            assign sb.ci        = sw_ci;
            assign sb.sub       = sw_sub;
            assign sb.in_valid  = sw_in_valid;
            assign sb.out_ready = sw_out_ready;
            assign sw_rdy[g]    = sb.in_ready;
            assign sw_vld[g]    = sb.out_valid;
            assign sw_co[g]     = sb.co;
            assign sw_ov[g]     = sb.ov;
            assign sw_s[g]      = sb.s;
            pipelined_adder #(.WIDTH(8), .STAGES(ST)) u_dut (.clk(clk), .rst_n(rst_n), .bus(sb));
        end
    endgenerate

    typedef struct {
        logic [15:0] a, b;
        logic        ci, sub;
        logic [15:0] s;
        logic        co, ov;
    } vec_t;

    vec_t       tbl [10];
    logic [7:0] vals [6];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic send_op(input string nm, input logic [15:0] a, input logic [15:0] b,
                           input logic ci, input logic sub,
                           input logic [15:0] es, input logic eco, input logic eov);
        int lat;
        @(negedge clk);
        bus.a = a; bus.b = b; bus.ci = ci; bus.sub = sub;
        bus.in_valid = 1'b1; bus.out_ready = 1'b1;
        @(negedge clk);
        bus.in_valid = 1'b0;
        lat = 1;
        while (!bus.out_valid && lat < 12) begin
            @(negedge clk);
            lat++;
        end
        chk({nm, "_lat"}, lat, 4);
        chk({nm, "_s"}, bus.s, es);
        chk({nm, "_co"}, bus.co, eco);
        chk({nm, "_ov"}, bus.ov, eov);
    endtask

    function automatic int sw_model(input logic [7:0] a, input logic [7:0] b, input logic ci, input logic sub);
        logic [7:0] bb;
        logic [8:0] full;
        bb   = sub ? ~b : b;
        full = {1'b0, a} + {1'b0, bb} + {8'b0, sub | ci};
        return int'({(a[7] == bb[7]) && (full[7] != a[7]), full[8], full[7:0]});
    endfunction

    task automatic sw_check(input int j, input int stg);
        int e, c;
        if (sw_vld[j] && sw_out_ready) begin
            if (sw_exp[j].size() == 0) begin
                chk($sformatf("sw_st%0d_extra", stg), 1, 0);
            end else begin
                e = sw_exp[j].pop_front();
                c = sw_acc[j].pop_front();
                chk($sformatf("sw_st%0d_res", stg), {22'b0, sw_ov[j], sw_co[j], sw_s[j]}, e);
                if (sw_phase1) chk($sformatf("sw_st%0d_lat", stg), sw_cyc - c, stg);
                else           chk($sformatf("sw_st%0d_latmin", stg), (sw_cyc - c) >= stg, 1);
            end
        end
        if (sw_in_valid && sw_rdy[j]) begin
            sw_exp[j].push_back(sw_model(sw_a, sw_b, sw_ci, sw_sub));
            sw_acc[j].push_back(sw_cyc);
        end
    endtask

    task automatic sw_step();
        @(negedge clk);
        sw_cyc++;
        sw_check(0, 1);
        sw_check(1, 2);
        sw_check(2, 8);
    endtask

    initial begin
        int got, sent, stalls, stall_left, dups, w;
        logic [15:0] ra [3];
        logic [15:0] rb [3];

        n_cmp = 0; n_bad = 0; sw_cyc = 0;
        tbl[0] = '{16'h00FF, 16'h0001, 1'b0, 1'b0, 16'h0100, 1'b0, 1'b0};
        tbl[1] = '{16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0};
        tbl[2] = '{16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1};
        tbl[3] = '{16'h0005, 16'h0007, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0};
        tbl[4] = '{16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1};
        tbl[5] = '{16'h1234, 16'h4321, 1'b1, 1'b0, 16'h5556, 1'b0, 1'b0};
        tbl[6] = '{16'h0010, 16'h0010, 1'b1, 1'b1, 16'h0000, 1'b1, 1'b0};
        tbl[7] = '{16'h8000, 16'h8000, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1};
        tbl[8] = '{16'hFFFF, 16'hFFFF, 1'b1, 1'b0, 16'hFFFF, 1'b1, 1'b0};
        tbl[9] = '{16'h0F0F, 16'h00F1, 1'b0, 1'b0, 16'h1000, 1'b0, 1'b0};
        vals   = '{8'h00, 8'h01, 8'h7F, 8'h80, 8'hFF, 8'h55};

        bus.a = '0; bus.b = '0; bus.ci = 1'b0; bus.sub = 1'b0;
        bus.in_valid = 1'b0; bus.out_ready = 1'b1;
        sw_a = '0; sw_b = '0; sw_ci = 1'b0; sw_sub = 1'b0;
        sw_in_valid = 1'b0; sw_out_ready = 1'b1; sw_phase1 = 1'b1;
        rst_n = 1'b0;

        repeat (3) @(negedge clk);
        chk("rst_out_valid", bus.out_valid, 0);
        chk("rst_s", bus.s, 0);
        chk("rst_co", bus.co, 0);
        chk("rst_ov", bus.ov, 0);
        rst_n = 1'b1;
        #1;
        chk("rst_in_ready", bus.in_ready, 1);

        for (int i = 0; i < 10; i++) begin
            send_op($sformatf("vec%0d", i), tbl[i].a, tbl[i].b, tbl[i].ci, tbl[i].sub,
                    tbl[i].s, tbl[i].co, tbl[i].ov);
        end

        // Eight back-to-back ops, three-cycle output stall after the first result
        got = 0; sent = 0; stalls = 0; stall_left = 0;
        for (int cyc = 0; cyc < 60 && got < 8; cyc++) begin
            @(negedge clk);
            bus.out_ready = (stall_left == 0);
            if (sent < 8) begin
                bus.a = 16'(sent + 1); bus.b = 16'(32'h1000 * (sent + 1));
                bus.ci = 1'b0; bus.sub = 1'b0; bus.in_valid = 1'b1;
            end else begin
                bus.in_valid = 1'b0;
            end
            #1;
            if (!bus.out_ready) begin
                stall_left--;
                stalls++;
                chk("bp_stall_in_ready", bus.in_ready, 0);
                chk("bp_stall_valid", bus.out_valid, 1);
                chk("bp_hold_s", bus.s, 16'(32'h1001 * (got + 1)));
            end else if (bus.out_valid) begin
                chk($sformatf("bp_s%0d", got), bus.s, 16'(32'h1001 * (got + 1)));
                chk($sformatf("bp_co%0d", got), {bus.co, bus.ov}, 0);
                got++;
                if (got == 1) stall_left = 3;
            end
            if (bus.in_valid && bus.in_ready) sent++;
        end
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b1;
        chk("bp_count", got, 8);
        chk("bp_stalls", stalls, 3);
        dups = 0;
        repeat (6) begin
            @(negedge clk);
            if (bus.out_valid) dups++;
        end
        chk("bp_no_dup", dups, 0);

        // Three ops piled up behind a stalled output, then asynchronous reset
        ra = '{16'hFFFF, 16'h0001, 16'h0003};
        rb = '{16'h8000, 16'h0002, 16'h0004};
        @(negedge clk);
        bus.out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            bus.a = ra[i]; bus.b = rb[i]; bus.ci = 1'b0; bus.sub = 1'b0; bus.in_valid = 1'b1;
            @(negedge clk);
        end
        bus.in_valid = 1'b0;
        w = 0;
        while (!bus.out_valid && w < 10) begin
            @(negedge clk);
            w++;
        end
        chk("mid_valid", bus.out_valid, 1);
        chk("mid_s", bus.s, 16'h7FFF);
        chk("mid_co_ov", {bus.co, bus.ov}, 2'b11);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_valid", bus.out_valid, 0);
        chk("arst_s", bus.s, 0);
        chk("arst_co_ov", {bus.co, bus.ov}, 0);
        @(negedge clk);
        #3;
        rst_n = 1'b1;
        bus.out_ready = 1'b1;
        dups = 0;
        repeat (8) begin
            @(negedge clk);
            if (bus.out_valid) dups++;
        end
        chk("arst_no_stale", dups, 0);
        send_op("post_rst", 16'h1234, 16'h0001, 1'b0, 1'b0, 16'h1235, 1'b0, 1'b0);
        @(negedge clk);

        // WIDTH=8 sweep: corner operands with a free-running output first
        sw_phase1 = 1'b1;
        for (int ia = 0; ia < 6; ia++) begin
            for (int ib = 0; ib < 6; ib++) begin
                for (int m = 0; m < 4; m++) begin
                    @(posedge clk);
                    #2;
                    sw_a = vals[ia]; sw_b = vals[ib]; sw_ci = m[0]; sw_sub = m[1];
                    sw_in_valid = 1'b1; sw_out_ready = 1'b1;
                    sw_step();
                end
            end
        end
        repeat (20) begin
            @(posedge clk);
            #2;
            sw_in_valid = 1'b0;
            sw_step();
        end
        sw_phase1 = 1'b0;
        repeat (1500) begin
            @(posedge clk);
            #2;
            sw_a = 8'($urandom); sw_b = 8'($urandom);
            sw_ci = 1'($urandom_range(0, 1)); sw_sub = 1'($urandom_range(0, 1));
            sw_in_valid = ($urandom_range(0, 3) != 0);
            sw_out_ready = 1'($urandom_range(0, 1));
            sw_step();
        end
        repeat (25) begin
            @(posedge clk);
            #2;
            sw_in_valid = 1'b0; sw_out_ready = 1'b1;
            sw_step();
        end
        chk("sw_st1_drain", sw_exp[0].size(), 0);
        chk("sw_st2_drain", sw_exp[1].size(), 0);
        chk("sw_st8_drain", sw_exp[2].size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
